// File: rtl/dsi_lane_scheduler.sv
// Packet scheduler in front of one dsi_lane. It arbitrates video, command and dummy-frame
// requests, grants one whole packet at a time and passes bytes to the lane write port with
// zero latency. After each packet it waits for the lane to return to LP-STOP, then idles
// for a fixed gap.
module dsi_lane_scheduler #(
  parameter int unsigned CMD_PRIORITY  = 1,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk_base,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       vid_valid,
  input  logic       vid_last,
  input  logic [7:0] vid_data,
  output logic       vid_ready,
  input  logic       cmd_valid,
  input  logic       cmd_last,
  input  logic [7:0] cmd_data,
  input  logic       cmd_hs,
  output logic       cmd_ready,
  input  logic       dummy_req,
  output logic       lane_data_write,
  output logic [7:0] lane_data_input,
  output logic       lane_end_of_frame,
  output logic       lane_data_type,
  output logic       lane_dummy_frame,
  input  logic       lane_data_ready,
  input  logic       lane_active,
  output logic [1:0] grant,
  output logic       busy,
  output logic       underrun_pulse,
  output logic [7:0] underrun_count
);

  typedef enum logic [2:0] {
    StIdle, StXfer, StDrain, StSettle, StWaitIdle, StGap
  } state_e;

  localparam logic [1:0] GntNone  = 2'b00;
  localparam logic [1:0] GntVid   = 2'b01;
  localparam logic [1:0] GntCmd   = 2'b10;
  localparam logic [1:0] GntDummy = 2'b11;

  // Counters load N-1 and run down to zero, so a state lasts exactly N cycles.
  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  localparam logic [7:0] GapLoad    = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       dummy_pend_q, dummy_pend_d;
  logic       rr_cmd_last_q, rr_cmd_last_d;
  logic       hs_q, hs_d;
  logic       started_q, started_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ur_count_q, ur_count_d;

  logic       src_valid, src_last, src_type, src_rdy;
  logic [7:0] src_data;
  logic       pick_cmd;
  logic       wr, eof, typ, dmy, ur_pulse;
  logic [7:0] din;

  // Granted-source mux; the command type is the mode latched on the grant cycle.
  always_comb begin
    src_valid = (grant_q == GntCmd) ? cmd_valid : vid_valid;
    src_last  = (grant_q == GntCmd) ? cmd_last  : vid_last;
    src_data  = (grant_q == GntCmd) ? cmd_data  : vid_data;
    src_type  = (grant_q == GntCmd) ? hs_q      : 1'b1;
    // Round-robin: command wins a tie only if video went last.
    pick_cmd  = cmd_valid && ((CMD_PRIORITY != 0) || !vid_valid || !rr_cmd_last_q);
  end

  // Next-state and lane/source handshake decode.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    dummy_pend_d  = dummy_pend_q | dummy_req;
    rr_cmd_last_d = rr_cmd_last_q;
    hs_d          = hs_q;
    started_d     = started_q;
    cnt_d         = cnt_q;
    ur_count_d    = ur_count_q;
    src_rdy       = 1'b0;
    wr            = 1'b0;
    din           = 8'h00;
    eof           = 1'b0;
    typ           = 1'b0;
    dmy           = 1'b0;
    ur_pulse      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable && !lane_active && lane_data_ready) begin
          if (pick_cmd) begin
            grant_d       = GntCmd;
            rr_cmd_last_d = 1'b1;
            hs_d          = cmd_hs;
            started_d     = 1'b0;
            state_d       = StXfer;
          end else if (vid_valid) begin
            grant_d       = GntVid;
            rr_cmd_last_d = 1'b0;
            started_d     = 1'b0;
            state_d       = StXfer;
          end else if (dummy_pend_q) begin
            grant_d   = GntDummy;
            started_d = 1'b0;
            state_d   = StXfer;
          end
        end
      end

      StXfer: begin
        if (grant_q == GntDummy) begin
          if (lane_data_ready) begin
            wr           = 1'b1;
            eof          = 1'b1;
            typ          = 1'b1;
            dmy          = 1'b1;
            // A request arriving on this very cycle queues the next dummy frame.
            dummy_pend_d = dummy_req;
            cnt_d        = SettleLoad;
            state_d      = StSettle;
          end
        end else begin
          src_rdy = src_valid && lane_data_ready;
          if (src_valid && lane_data_ready) begin
            wr        = 1'b1;
            din       = src_data;
            eof       = src_last;
            typ       = src_type;
            started_d = 1'b1;
            if (src_last) begin
              cnt_d   = SettleLoad;
              state_d = StSettle;
            end
          end else if (started_q && lane_data_ready) begin
            // Source stalled mid-packet: close the frame on the lane with a zero byte.
            wr       = 1'b1;
            eof      = 1'b1;
            typ      = src_type;
            ur_pulse = 1'b1;
            if (ur_count_q != 8'hff) begin
              ur_count_d = ur_count_q + 8'd1;
            end
            state_d  = StDrain;
          end
        end
      end

      StDrain: begin
        src_rdy = 1'b1;
        if (src_valid && src_last) begin
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end
      end

      StSettle: begin
        if (cnt_q == 8'd0) begin
          state_d = StWaitIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StWaitIdle: begin
        if (!lane_active) begin
          cnt_d   = GapLoad;
          state_d = StGap;
        end
      end

      StGap: begin
        if (cnt_q == 8'd0) begin
          grant_d = GntNone;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        grant_d = GntNone;
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_base) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      grant_q       <= GntNone;
      dummy_pend_q  <= 1'b0;
      rr_cmd_last_q <= 1'b1;
      hs_q          <= 1'b0;
      started_q     <= 1'b0;
      cnt_q         <= 8'd0;
      ur_count_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      dummy_pend_q  <= dummy_pend_d;
      rr_cmd_last_q <= rr_cmd_last_d;
      hs_q          <= hs_d;
      started_q     <= started_d;
      cnt_q         <= cnt_d;
      ur_count_q    <= ur_count_d;
    end
  end

  // Outputs are forced low whenever reset is asserted, even before the sampling edge.
  always_comb begin
    vid_ready         = reset_n && src_rdy && (grant_q == GntVid);
    cmd_ready         = reset_n && src_rdy && (grant_q == GntCmd);
    lane_data_write   = reset_n && wr;
    lane_data_input   = reset_n ? din : 8'h00;
    lane_end_of_frame = reset_n && eof;
    lane_data_type    = reset_n && typ;
    lane_dummy_frame  = reset_n && dmy;
    grant             = reset_n ? grant_q : GntNone;
    busy              = reset_n && (state_q != StIdle);
    underrun_pulse    = reset_n && ur_pulse;
    underrun_count    = reset_n ? ur_count_q : 8'h00;
  end

endmodule
